// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - program counter owner with branch/jump redirect, IF/ID flush and stalled-redirect capture
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             FetchStall,
    input  logic             EqualFlag,
    input  logic [5:0]       BranchControl,
    input  logic [31:0]      BranchTarget,
    input  logic [31:0]      JumpTarget,
    input  logic [31:0]      RegTarget,
    output logic [31:0]      PC,
    output logic             IFIDFlush,
    output logic             Pending,
    output logic             AlignErr,
    output logic [CNT_W-1:0] RedirectCount
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [5:0] CODE_BEQ = 6'd18;
    localparam logic [5:0] CODE_BNE = 6'd19;
    localparam logic [5:0] CODE_J   = 6'd23;
    localparam logic [5:0] CODE_JR  = 6'd24;
    localparam logic [5:0] CODE_JAL = 6'd25;

    state_t           state;
    state_t           stateNext;
    logic [31:0]      pcReg;
    logic [31:0]      pcNext;
    logic [31:0]      pendTarget;
    logic [31:0]      pendTargetNext;
    logic             alignReg;
    logic [CNT_W-1:0] countReg;

    logic             isRedirCode;
    logic             take;
    logic [31:0]      rawTarget;
    logic [31:0]      alignedTarget;
    logic             alignBad;
    logic             flush;
    logic             countInc;
    logic             alignSet;

    // Decode the control code and pick the raw target before alignment.
    always_comb begin
        isRedirCode = 1'b0;
        rawTarget   = 32'h0;
        case (BranchControl)
            CODE_BEQ, CODE_BNE: begin
                isRedirCode = 1'b1;
                rawTarget   = BranchTarget;
            end
            CODE_J, CODE_JAL: begin
                isRedirCode = 1'b1;
                rawTarget   = JumpTarget;
            end
            CODE_JR: begin
                isRedirCode = 1'b1;
                rawTarget   = RegTarget;
            end
            default: begin
                isRedirCode = 1'b0;
                rawTarget   = 32'h0;
            end
        endcase
        take          = EqualFlag & isRedirCode;
        alignedTarget = {rawTarget[31:2], 2'b00};
        alignBad      = (rawTarget[1:0] != 2'b00);
    end

    // In PEND the ID stage holds a wrong-path bubble, so take is ignored.
    always_comb begin
        stateNext      = state;
        pcNext         = pcReg;
        pendTargetNext = pendTarget;
        flush          = 1'b0;
        countInc       = 1'b0;
        alignSet       = 1'b0;
        case (state)
            RUN: begin
                if (take) begin
                    flush    = 1'b1;
                    countInc = 1'b1;
                    alignSet = alignBad;
                    if (FetchStall) begin
                        pendTargetNext = alignedTarget;
                        stateNext      = PEND;
                    end else begin
                        pcNext = alignedTarget;
                    end
                end else if (!FetchStall) begin
                    pcNext = pcReg + 32'd4;
                end
            end
            PEND: begin
                if (!FetchStall) begin
                    pcNext    = pendTarget;
                    stateNext = RUN;
                end
            end
            default: begin
                stateNext = RUN;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= RUN;
            pcReg      <= RESET_PC;
            pendTarget <= 32'h0;
            alignReg   <= 1'b0;
            countReg   <= '0;
        end else begin
            state      <= stateNext;
            pcReg      <= pcNext;
            pendTarget <= pendTargetNext;
            if (alignSet) begin
                alignReg <= 1'b1;
            end
            if (countInc && (countReg != {CNT_W{1'b1}})) begin
                countReg <= countReg + 1'b1;
            end
        end
    end

    assign PC            = pcReg;
    assign IFIDFlush     = flush & ~Rst;
    assign Pending       = (state == PEND);
    assign AlignErr      = alignReg;
    assign RedirectCount = countReg;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - table-driven scoreboard bench for pc_redirect_unit
module tb_pc_redirect_unit;

    logic        Clk;
    logic        Rst;
    logic        FetchStall;
    logic        EqualFlag;
    logic [5:0]  BranchControl;
    logic [31:0] BranchTarget;
    logic [31:0] JumpTarget;
    logic [31:0] RegTarget;
    logic [31:0] PC;
    logic        IFIDFlush;
    logic        Pending;
    logic        AlignErr;
    logic [15:0] RedirectCount;

    logic [31:0] smallPC;
    logic        smallFlush;
    logic        smallPending;
    logic        smallAlign;
    logic [1:0]  smallCount;

    pc_redirect_unit dut (
        .Clk(Clk), .Rst(Rst), .FetchStall(FetchStall), .EqualFlag(EqualFlag),
        .BranchControl(BranchControl), .BranchTarget(BranchTarget),
        .JumpTarget(JumpTarget), .RegTarget(RegTarget), .PC(PC),
        .IFIDFlush(IFIDFlush), .Pending(Pending), .AlignErr(AlignErr),
        .RedirectCount(RedirectCount)
    );

    pc_redirect_unit #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dutSmall (
        .Clk(Clk), .Rst(Rst), .FetchStall(FetchStall), .EqualFlag(EqualFlag),
        .BranchControl(BranchControl), .BranchTarget(BranchTarget),
        .JumpTarget(JumpTarget), .RegTarget(RegTarget), .PC(smallPC),
        .IFIDFlush(smallFlush), .Pending(smallPending), .AlignErr(smallAlign),
        .RedirectCount(smallCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic        fs;
        logic        eq;
        logic [5:0]  bc;
        logic [31:0] bt;
        logic [31:0] jt;
        logic [31:0] rt;
        logic        flush;
        logic [31:0] pc;
        logic        pend;
        logic        align;
        logic [15:0] cnt;
        logic [1:0]  scnt;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic        pend;
        logic        align;
        logic [15:0] cnt;
        logic [1:0]  scnt;
    } exp_t;

    exp_t expQ[$];
    vec_t table_v[17];
    int   checks = 0;
    int   errors = 0;
    int   vecIdx = 0;

    function automatic vec_t mk(logic rst, logic fs, logic eq, logic [5:0] bc,
                                logic [31:0] bt, logic [31:0] jt, logic [31:0] rt,
                                logic flush, logic [31:0] pc, logic pend,
                                logic align, logic [15:0] cnt, logic [1:0] scnt);
        vec_t v;
        v.rst = rst; v.fs = fs; v.eq = eq; v.bc = bc;
        v.bt = bt; v.jt = jt; v.rt = rt;
        v.flush = flush; v.pc = pc; v.pend = pend;
        v.align = align; v.cnt = cnt; v.scnt = scnt;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", idx, name, act, exp);
        end
    endtask

    // Drive one cycle: flush checked combinationally, registered state via the scoreboard.
    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge Clk);
        Rst           = v.rst;
        FetchStall    = v.fs;
        EqualFlag     = v.eq;
        BranchControl = v.bc;
        BranchTarget  = v.bt;
        JumpTarget    = v.jt;
        RegTarget     = v.rt;
        #1;
        check("flush", vecIdx, {31'b0, IFIDFlush}, {31'b0, v.flush});
        e.idx = vecIdx; e.pc = v.pc; e.pend = v.pend;
        e.align = v.align; e.cnt = v.cnt; e.scnt = v.scnt;
        expQ.push_back(e);
        @(posedge Clk);
        #1;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL vec%0d scoreboard: got empty queue expected entry", vecIdx);
        end else begin
            got = expQ.pop_front();
            check("pc",      got.idx, PC,                      got.pc);
            check("pending", got.idx, {31'b0, Pending},        {31'b0, got.pend});
            check("alignerr",got.idx, {31'b0, AlignErr},       {31'b0, got.align});
            check("count",   got.idx, {16'b0, RedirectCount},  {16'b0, got.cnt});
            check("smallcnt",got.idx, {30'b0, smallCount},     {30'b0, got.scnt});
        end
        vecIdx++;
    endtask

    initial begin
        Rst = 1'b1; FetchStall = 1'b0; EqualFlag = 1'b0; BranchControl = 6'd0;
        BranchTarget = 32'h0; JumpTarget = 32'h0; RegTarget = 32'h0;

        table_v[0]  = mk(1, 0, 0, 6'd0,  32'h0,   32'h0,   32'h0,   0, 32'h0,   0, 0, 16'd0, 2'd0);
        table_v[1]  = mk(0, 0, 0, 6'd0,  32'h0,   32'h0,   32'h0,   0, 32'h4,   0, 0, 16'd0, 2'd0);
        table_v[2]  = mk(0, 0, 0, 6'd0,  32'h0,   32'h0,   32'h0,   0, 32'h8,   0, 0, 16'd0, 2'd0);
        table_v[3]  = mk(0, 0, 0, 6'd0,  32'h0,   32'h0,   32'h0,   0, 32'hC,   0, 0, 16'd0, 2'd0);
        table_v[4]  = mk(0, 0, 0, 6'd0,  32'h0,   32'h0,   32'h0,   0, 32'h10,  0, 0, 16'd0, 2'd0);
        table_v[5]  = mk(0, 0, 1, 6'd18, 32'h40,  32'h0,   32'h0,   1, 32'h40,  0, 0, 16'd1, 2'd1);
        table_v[6]  = mk(0, 0, 0, 6'd18, 32'h80,  32'h0,   32'h0,   0, 32'h44,  0, 0, 16'd1, 2'd1);
        table_v[7]  = mk(0, 1, 1, 6'd24, 32'h0,   32'h0,   32'h102, 1, 32'h44,  1, 1, 16'd2, 2'd2);
        table_v[8]  = mk(0, 1, 1, 6'd23, 32'h0,   32'h200, 32'h0,   0, 32'h44,  1, 1, 16'd2, 2'd2);
        table_v[9]  = mk(0, 1, 0, 6'd0,  32'h0,   32'h0,   32'h0,   0, 32'h44,  1, 1, 16'd2, 2'd2);
        table_v[10] = mk(0, 0, 1, 6'd23, 32'h0,   32'h200, 32'h0,   0, 32'h100, 0, 1, 16'd2, 2'd2);
        table_v[11] = mk(0, 0, 1, 6'd7,  32'h400, 32'h400, 32'h400, 0, 32'h104, 0, 1, 16'd2, 2'd2);
        table_v[12] = mk(0, 0, 1, 6'd19, 32'h300, 32'h0,   32'h0,   1, 32'h300, 0, 1, 16'd3, 2'd3);
        table_v[13] = mk(0, 0, 1, 6'd25, 32'h0,   32'hFFFF_FFFC, 32'h0, 1, 32'hFFFF_FFFC, 0, 1, 16'd4, 2'd3);
        table_v[14] = mk(0, 0, 0, 6'd0,  32'h0,   32'h0,   32'h0,   0, 32'h0,   0, 1, 16'd4, 2'd3);
        table_v[15] = mk(0, 1, 0, 6'd0,  32'h0,   32'h0,   32'h0,   0, 32'h0,   0, 1, 16'd4, 2'd3);
        table_v[16] = mk(0, 0, 0, 6'd23, 32'h0,   32'h10,  32'h0,   0, 32'h4,   0, 1, 16'd4, 2'd3);

        for (int i = 0; i < 17; i++) begin
            apply(table_v[i]);
        end

        // Reset while a stalled redirect is captured: target must be discarded.
        apply(mk(0, 1, 1, 6'd18, 32'h500, 32'h0, 32'h0, 1, 32'h4, 1, 1, 16'd5, 2'd3));
        apply(mk(1, 1, 1, 6'd18, 32'h500, 32'h0, 32'h0, 0, 32'h0, 0, 0, 16'd0, 2'd0));
        apply(mk(0, 0, 0, 6'd0,  32'h0,   32'h0, 32'h0, 0, 32'h4, 0, 0, 16'd0, 2'd0));

        // Back-to-back jumps: the 2-bit counter saturates at 3, the 16-bit one keeps counting.
        for (int i = 0; i < 5; i++) begin
            logic [31:0] tgt;
            logic [1:0]  sat;
            tgt = 32'h1000 + 32'(i) * 32'h10;
            sat = (i >= 2) ? 2'd3 : 2'(i + 1);
            apply(mk(0, 0, 1, 6'd23, 32'h0, tgt, 32'h0, 1, tgt, 0, 0, 16'(i + 1), sat));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Downstream consumer of the ID-stage equality/branch comparator flag; owns the program counter register.
- Selects the next PC (sequential, branch, jump, or jump-register target), flushes IF/ID on a taken redirect, and captures a redirect that resolves while fetch is stalled.
- Sits between ID-stage branch resolution and the IF-stage instruction memory address port.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating taken-redirect counter.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- FetchStall  input  1  IF stage cannot advance; PC must hold. ID/EX continue.
- EqualFlag  input  1  comparator result from ID (1 = take redirect for the current control code).
- BranchControl  input  6  ID control code: 18 beq, 19 bne, 23 j, 24 jr, 25 jal; all others are non-redirecting.
- BranchTarget  input  32  ID-computed PC+4+(sext(imm)<<2).
- JumpTarget  input  32  ID-computed {PC+4[31:28], addr26, 2'b00}.
- RegTarget  input  32  forwarded rs value for jr.
- PC  output  32  current fetch address (registered).
- IFIDFlush  output  1  combinational; IF/ID register loads a bubble at this edge.
- Pending  output  1  registered; a captured redirect is waiting for fetch to resume.
- AlignErr  output  1  sticky; set when a selected target has bits [1:0] != 0.
- RedirectCount  output  CNT_W  saturating count of accepted redirects.

Behaviour:
- Reset (Rst=1 at an edge): PC=RESET_PC, Pending=0, pending target=0, AlignErr=0, RedirectCount=0. State is RUN. Rst has priority over every other input.
- Redirect request `take` = EqualFlag & (BranchControl in {18,19,23,24,25}). Codes outside this set never redirect, regardless of EqualFlag.
- Target mux: 18/19 select BranchTarget; 23/25 select JumpTarget; 24 selects RegTarget.
- The selected target is written with bits [1:0] forced to 00. If the raw bits [1:0] != 0, AlignErr is set and stays set until Rst.
- State RUN:
  - take & !FetchStall: PC <= target; IFIDFlush=1 in the same cycle; RedirectCount += 1. Stay in RUN.
  - take & FetchStall: latch target into the pending register; Pending <= 1; IFIDFlush=1; RedirectCount += 1; PC holds. Go to PEND.
  - !take & !FetchStall: PC <= PC + 4, 32-bit wrap (32'hFFFF_FFFC -> 0).
  - !take & FetchStall: PC holds.
- State PEND:
  - FetchStall=1: hold PC and the pending target.
  - FetchStall=0: PC <= pending target; Pending <= 0. Go to RUN.
  - `take` is ignored while in PEND (ID holds a wrong-path bubble): no flush, no count, no target overwrite.
- IFIDFlush is 0 in PEND, 0 during any cycle with Rst=1, and 0 whenever take=0.
- Latency: a redirect resolved in cycle N is on PC after edge N when not stalled. If stalled, it appears after the first edge at which FetchStall=0.
- RedirectCount saturates at all-ones and does not wrap.
- Reset mid-PEND discards the pending target; PC=RESET_PC after that edge.

Test Plan:
- Reset release, FetchStall=0, no branches for 4 cycles -> PC sequence 0, 4, 8, 12, 16; IFIDFlush=0; RedirectCount=0.
- BranchControl=18, EqualFlag=1, BranchTarget=32'h0000_0040, no stall -> IFIDFlush=1 that cycle; PC=0x40 next cycle; RedirectCount=1. Repeat with EqualFlag=0 -> PC+4 and no flush.
- BranchControl=24, RegTarget=32'h0000_0102, FetchStall=1 for 3 cycles -> Pending=1 and PC held for those cycles; AlignErr=1. First unstalled edge -> PC=0x100, Pending=0.
- While Pending=1, drive BranchControl=23, EqualFlag=1, JumpTarget=0x200 -> ignored. On stall release, PC equals the original pending target; IFIDFlush=0 during PEND.
- BranchControl=7, EqualFlag=1 -> no redirect, no flush; PC+4.
- PC=32'hFFFF_FFFC, no branch -> PC=0. Then Rst asserted during PEND -> PC=RESET_PC, Pending=0, RedirectCount=0, AlignErr=0. With CNT_W=2, five redirects -> RedirectCount=3.
